// File: rtl/regfile_port_sequencer.sv
// Serializes one write-back plus two operand fetches onto the shared register-file port
// and returns both operands on a valid/ready response channel. x0 is handled here.
module regfile_port_sequencer #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   req_rs1,
  input  logic [AW-1:0]   req_rs2,
  input  logic [AW-1:0]   req_rd,
  input  logic            req_rd_we,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rs1_data,
  output logic [XLEN-1:0] rsp_rs2_data,
  output logic            rf_en,
  output logic            rf_ld_str,
  output logic [AW-1:0]   rf_addr,
  output logic [XLEN-1:0] rf_store_val,
  input  logic [XLEN-1:0] rf_load_val
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD1  = 3'd2,
    RD2  = 3'd3,
    CAP  = 3'd4,
    RESP = 3'd5
  } state_t;

  state_t        state_reg;
  logic [AW-1:0] rs1_reg;
  logic [AW-1:0] rs2_reg;

  // Gating with reset keeps ready low during reset yet high in the first cycle after release.
  assign req_ready = (state_reg == IDLE) && !reset;

  // Port outputs are registered for the state being entered, so each access
  // occupies exactly the cycle of its state and nothing leaks from req_* combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      rs1_reg      <= '0;
      rs2_reg      <= '0;
      rsp_valid    <= 1'b0;
      rsp_rs1_data <= '0;
      rsp_rs2_data <= '0;
      rf_en        <= 1'b0;
      rf_ld_str    <= 1'b1;
      rf_addr      <= '0;
      rf_store_val <= '0;
    end else begin
      rf_en        <= 1'b0;
      rf_ld_str    <= 1'b1;
      rf_addr      <= '0;
      rf_store_val <= '0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            rs1_reg   <= req_rs1;
            rs2_reg   <= req_rs2;
            state_reg <= WR;
            if (req_rd_we && (req_rd != '0)) begin
              rf_en        <= 1'b1;
              rf_ld_str    <= 1'b0;
              rf_addr      <= req_rd;
              rf_store_val <= req_wdata;
            end
          end
        end
        WR: begin
          state_reg <= RD1;
          if (rs1_reg != '0) begin
            rf_en   <= 1'b1;
            rf_addr <= rs1_reg;
          end
        end
        RD1: begin
          state_reg <= RD2;
          if (rs2_reg != '0) begin
            rf_en   <= 1'b1;
            rf_addr <= rs2_reg;
          end
        end
        RD2: begin
          state_reg    <= CAP;
          rsp_rs1_data <= (rs1_reg != '0) ? rf_load_val : '0;
        end
        CAP: begin
          state_reg    <= RESP;
          rsp_rs2_data <= (rs2_reg != '0) ? rf_load_val : '0;
          rsp_valid    <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_port_sequencer.sv
// Bench for regfile_port_sequencer: behavioral register file on the rf port, shadow
// architectural state for expectations, and a response scoreboard.
module tb_regfile_port_sequencer;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [4:0]  req_rd;
  logic        req_rd_we;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rs1_data;
  logic [31:0] rsp_rs2_data;
  logic        rf_en;
  logic        rf_ld_str;
  logic [4:0]  rf_addr;
  logic [31:0] rf_store_val;
  logic [31:0] rf_load_val;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem  [32];
  logic [31:0] arch [32];
  logic [31:0] exp_rs1_q[$];
  logic [31:0] exp_rs2_q[$];

  regfile_port_sequencer #(.XLEN(32), .AW(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rs1      (req_rs1),
    .req_rs2      (req_rs2),
    .req_rd       (req_rd),
    .req_rd_we    (req_rd_we),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rs1_data (rsp_rs1_data),
    .rsp_rs2_data (rsp_rs2_data),
    .rf_en        (rf_en),
    .rf_ld_str    (rf_ld_str),
    .rf_addr      (rf_addr),
    .rf_store_val (rf_store_val),
    .rf_load_val  (rf_load_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file honoring the port contract: act at the edge ending an rf_en cycle.
  always @(posedge clk) begin
    if (rf_en) begin
      if (!rf_ld_str) mem[rf_addr] <= rf_store_val;
      else            rf_load_val  <= mem[rf_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_port(input string tag);
    check({tag, "_en"},  {31'd0, rf_en}, 32'd0);
    check({tag, "_ls"},  {31'd0, rf_ld_str}, 32'd1);
    check({tag, "_adr"}, {27'd0, rf_addr}, 32'd0);
    check({tag, "_val"}, rf_store_val, 32'd0);
  endtask

  // Runs one full transaction from an IDLE cycle; bp = cycles of rsp_ready=0 after rsp_valid.
  task automatic run_req(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic we, input logic [31:0] wd, input int bp);
    logic        wr;
    logic [31:0] e1, e2, g1, g2;
    wr = we && (rd != 5'd0);
    if (wr) arch[rd] = wd;
    e1 = (rs1 == 5'd0) ? 32'd0 : arch[rs1];
    e2 = (rs2 == 5'd0) ? 32'd0 : arch[rs2];
    exp_rs1_q.push_back(e1);
    exp_rs2_q.push_back(e2);
    $display("txn rs1=%0d rs2=%0d rd=%0d we=%0d wdata=%h bp=%0d exp=%h/%h", rs1, rs2, rd, we, wd, bp, e1, e2);

    check("c0_ready", {31'd0, req_ready}, 32'd1);
    req_rs1 = rs1; req_rs2 = rs2; req_rd = rd; req_rd_we = we; req_wdata = wd;
    req_valid = 1'b1;
    rsp_ready = (bp == 0);
    step();
    // Keep garbage requests present while busy; they must be ignored.
    req_rs1 = 5'($urandom); req_rs2 = 5'($urandom); req_rd = 5'($urandom);
    req_rd_we = 1'b1; req_wdata = $urandom;
    check("c1_ready", {31'd0, req_ready}, 32'd0);
    check("c1_en", {31'd0, rf_en}, {31'd0, wr});
    if (wr) begin
      check("c1_ls",  {31'd0, rf_ld_str}, 32'd0);
      check("c1_adr", {27'd0, rf_addr}, {27'd0, rd});
      check("c1_val", rf_store_val, wd);
    end else check_idle_port("c1");
    step();
    check("c2_en", {31'd0, rf_en}, {31'd0, (rs1 != 5'd0)});
    if (rs1 != 5'd0) begin
      check("c2_ls",  {31'd0, rf_ld_str}, 32'd1);
      check("c2_adr", {27'd0, rf_addr}, {27'd0, rs1});
    end else check_idle_port("c2");
    step();
    check("c3_en", {31'd0, rf_en}, {31'd0, (rs2 != 5'd0)});
    if (rs2 != 5'd0) begin
      check("c3_ls",  {31'd0, rf_ld_str}, 32'd1);
      check("c3_adr", {27'd0, rf_addr}, {27'd0, rs2});
    end else check_idle_port("c3");
    step();
    check_idle_port("c4");
    check("c4_vld", {31'd0, rsp_valid}, 32'd0);
    step();
    g1 = rsp_rs1_data;
    g2 = rsp_rs2_data;
    for (int i = 0; i < bp; i++) begin
      check("bp_vld",   {31'd0, rsp_valid}, 32'd1);
      check("bp_ready", {31'd0, req_ready}, 32'd0);
      check("bp_rs1",   rsp_rs1_data, g1);
      check("bp_rs2",   rsp_rs2_data, g2);
      check("bp_en",    {31'd0, rf_en}, 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    check("rsp_vld", {31'd0, rsp_valid}, 32'd1);
    check("rsp_rs1", rsp_rs1_data, exp_rs1_q.pop_front());
    check("rsp_rs2", rsp_rs2_data, exp_rs2_q.pop_front());
    step();
    check("end_vld",   {31'd0, rsp_valid}, 32'd0);
    check("end_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i]  = 32'h1000_0000 + i;
      arch[i] = 32'h1000_0000 + i;
    end
    mem[0] = 32'hBAD0_BAD0;
    reset = 1'b1;
    req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; req_rd = '0; req_rd_we = 1'b0; req_wdata = '0;
    rsp_ready = 1'b0;
    step();
    req_valid = 1'b1;
    step();
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_vld",   {31'd0, rsp_valid}, 32'd0);
    check("rst_rs1",   rsp_rs1_data, 32'd0);
    check("rst_rs2",   rsp_rs2_data, 32'd0);
    check_idle_port("rst");
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);

    run_req(5'd5, 5'd0, 5'd5, 1'b1, 32'hDEAD_BEEF, 0);
    run_req(5'd0, 5'd0, 5'd0, 1'b1, 32'h0000_1234, 0);
    run_req(5'd7, 5'd7, 5'd7, 1'b1, 32'hA5A5_A5A5, 0);
    run_req(5'd0, 5'd0, 5'd31, 1'b1, 32'h1111_1111, 0);
    run_req(5'd0, 5'd0, 5'd1, 1'b1, 32'h2222_2222, 0);
    run_req(5'd31, 5'd1, 5'd0, 1'b0, 32'h0, 0);
    run_req(5'd31, 5'd7, 5'd3, 1'b1, 32'h3333_3333, 3);
    for (int k = 0; k < 10; k++)
      run_req(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, 2)));

    // Abandoned write: x9 must keep its old value across a reset during WR.
    run_req(5'd9, 5'd0, 5'd9, 1'b1, 32'h0000_0005, 0);
    req_rs1 = 5'd0; req_rs2 = 5'd0; req_rd = 5'd9; req_rd_we = 1'b1; req_wdata = 32'hCAFE_F00D;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    check("mid_en", {31'd0, rf_en}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    $display("reset asserted during WR");
    check("mid_ready", {31'd0, req_ready}, 32'd0);
    check("mid_vld",   {31'd0, rsp_valid}, 32'd0);
    check("mid_rs1",   rsp_rs1_data, 32'd0);
    check("mid_rs2",   rsp_rs2_data, 32'd0);
    check_idle_port("mid");
    step();
    reset = 1'b0;
    #1;
    check("x9_mem", mem[9], 32'h0000_0005);
    step();
    run_req(5'd9, 5'd0, 5'd0, 1'b0, 32'h0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
